trigger_sequence_injector: RTL and testbench
============================================

// Module: trigger_sequence_injector
// PURPOSE
// - Transmit side of the plaintext-sequence trigger interface. On start, drives the fixed 4-word
//   128-bit sequence W0..W3 into the AES core's state input using a valid/ready handshake.
// - Sits between the test/control host and the AES core input mux.
// - Used to arm and fire the sequence detector in trust-evaluation and regression runs.
// PARAMETERS
// - W0          128'h3243f6a8_885a308d_313198a2_e0370734   first word sent
// - W1          128'h00112233_44556677_8899aabb_ccddeeff   second word sent
// - W2          128'h0                                     third word sent
// - W3          128'h1                                     fourth (last) word sent
// - GAP_CYCLES  0   idle cycles (valid low) inserted after every accepted word except the final one
// - REPEAT      1   number of full W0..W3 passes per start (REPEAT >= 1)
// PORTS
// - clk         in   1    clock; all state changes occur on the rising edge
// - rst         in   1    asynchronous, active-high reset
// - start       in   1    1-cycle request to begin a run; ignored unless the block is in IDLE
// - abort       in   1    synchronous cancel; has priority over all other inputs except rst
// - out_ready   in   1    AES input can accept a word this cycle
// - out_valid   out  1    out_state holds a valid word
// - out_state   out  128  current sequence word
// - out_last    out  1    high with out_valid when the word is W3 of the final pass
// - busy        out  1    high in every state other than IDLE
// - done        out  1    1-cycle pulse after the last word of the last pass is accepted
// - pass_cnt    out  8    number of completed passes in the current run
// BEHAVIOUR
// - Reset values: out_valid=0, out_state=0, out_last=0, busy=0, done=0, pass_cnt=0, FSM=IDLE.
// - States: IDLE, SEND, GAP, DONE. Word index idx (2b) and gap counter are internal.
// - IDLE: if start=1 (and abort=0), the next cycle enters SEND with idx=0 and pass_cnt=0.
//   There is 1 cycle of latency from start to out_valid=1.
// - SEND: out_valid=1, out_state=W[idx]. Data is held stable until the handshake completes
//   (out_valid & out_ready).
//   - Accept with idx<3: if GAP_CYCLES=0, stay in SEND with idx+1 (back-to-back words possible);
//     otherwise go to GAP.
//   - Accept with idx=3: pass_cnt+1. If pass_cnt+1 < REPEAT, go to GAP (if GAP_CYCLES>0) or SEND
//     with idx=0. Otherwise go to DONE.
// - GAP: out_valid=0 for exactly GAP_CYCLES cycles, then SEND with the next idx.
// - DONE: done=1 for one cycle, out_valid=0, then IDLE. pass_cnt holds until the next start.
// - out_state is 0 whenever out_valid=0.
// - Never deassert out_valid or change out_state while out_valid=1 and out_ready=0;
//   abort and rst are the only exceptions.
// - abort=1 in any state: the next cycle is IDLE with out_valid=0. No done pulse.
//   pass_cnt is retained. A word presented in the abort cycle counts as accepted only if
//   out_ready=1 in that same cycle.
// - start while busy: ignored, no restart.
// - start and abort in the same cycle: abort wins.
// - rst mid-operation: all outputs go to their reset values immediately (asynchronous).
// - pass_cnt saturates at 255. REPEAT is limited to 255.
// TESTING
// - GAP=0, REPEAT=1, out_ready=1 constant, start pulse -> W0,W1,W2,W3 on 4 consecutive cycles
//   starting 1 cycle after start; out_last only with W3; done 1 cycle later; pass_cnt=1.
// - out_ready low for 3 cycles while W1 is presented -> out_valid and W1 held stable for all
//   3 cycles; W2 appears the cycle after ready goes high.
// - GAP_CYCLES=2, REPEAT=2 -> 8 words W0..W3,W0..W3 with exactly 2 invalid cycles between
//   accepts; out_last only on the 8th word; pass_cnt=2; done once.
// - abort while W2 is stalled -> out_valid=0 and busy=0 the next cycle; no done;
//   a new start restarts from W0.
// - rst asserted mid-GAP -> all outputs 0 with no clock edge needed; start after rst
//   deassertion produces the full sequence.
// - start pulsed again during a run and simultaneously with abort -> ignored; abort honoured.

Source files
------------

// File: rtl/trigger_sequence_injector.sv
// Transmit side of the plaintext-sequence trigger interface: on start, plays the fixed
// words W0..W3 (REPEAT passes, optional idle gaps) into the AES state input over valid/ready.
module trigger_sequence_injector #(
  parameter logic [127:0] W0         = 128'h3243f6a8_885a308d_313198a2_e0370734,
  parameter logic [127:0] W1         = 128'h00112233_44556677_8899aabb_ccddeeff,
  parameter logic [127:0] W2         = 128'h0,
  parameter logic [127:0] W3         = 128'h1,
  parameter int unsigned  GAP_CYCLES = 0,
  parameter int unsigned  REPEAT     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [127:0] out_state,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic [7:0]   pass_cnt,
  output logic [1:0]   state_dbg
);

  // Handshake: a word transfers on any rising edge where out_valid & out_ready are both high;
  // while out_valid is high and out_ready low, out_valid and out_state stay frozen
  // (only abort or rst may withdraw the word).

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam bit            HAS_GAP  = (GAP_CYCLES != 0);
  localparam logic [15:0]   GAP_LOAD = HAS_GAP ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam logic [8:0]    REPEAT_W = 9'(REPEAT);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]  pass_cnt_q, pass_cnt_d;

  logic        accept;
  logic        more_passes;
  logic [7:0]  pass_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      gap_cnt_q  <= 16'd0;
      pass_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_cnt_q  <= gap_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign accept      = out_valid & out_ready;
  assign pass_inc    = (pass_cnt_q == 8'hFF) ? pass_cnt_q : pass_cnt_q + 8'd1;
  // Decided against the pre-increment count so the last word of the run can be flagged early.
  assign more_passes = ({1'b0, pass_cnt_q} + 9'd1) < REPEAT_W;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_cnt_d  = gap_cnt_q;
    pass_cnt_d = pass_cnt_q;
    if (abort) begin
      state_d = IDLE;
      if (accept && idx_q == 2'd3) pass_cnt_d = pass_inc;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = SEND;
            idx_d      = 2'd0;
            pass_cnt_d = 8'd0;
          end
        end
        SEND: begin
          if (accept) begin
            idx_d = idx_q + 2'd1;
            if (idx_q != 2'd3) begin
              if (HAS_GAP) begin
                state_d   = GAP;
                gap_cnt_d = GAP_LOAD;
              end
            end else begin
              pass_cnt_d = pass_inc;
              if (!more_passes) begin
                state_d = DONE;
              end else if (HAS_GAP) begin
                state_d   = GAP;
                gap_cnt_d = GAP_LOAD;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == 16'd0) state_d = SEND;
          else                    gap_cnt_d = gap_cnt_q - 16'd1;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    out_state = 128'd0;
    if (out_valid) begin
      case (idx_q)
        2'd0:    out_state = W0;
        2'd1:    out_state = W1;
        2'd2:    out_state = W2;
        default: out_state = W3;
      endcase
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && (idx_q == 2'd3) && !more_passes;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pass_cnt  = pass_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_trigger_sequence_injector.sv
// Directed bench for trigger_sequence_injector: a default instance (no gap, one pass)
// and a second instance with two-cycle gaps and two passes.
module tb_trigger_sequence_injector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         s0_start = 0, s0_abort = 0, s0_ready = 0;
  logic         s0_valid, s0_last, s0_busy, s0_done;
  logic [127:0] s0_state;
  logic [7:0]   s0_pass;
  logic [1:0]   s0_dbg;

  logic         s1_start = 0, s1_abort = 0, s1_ready = 0;
  logic         s1_valid, s1_last, s1_busy, s1_done;
  logic [127:0] s1_state;
  logic [7:0]   s1_pass;
  logic [1:0]   s1_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] wv [4];

  trigger_sequence_injector dut0 (
    .clk(clk), .rst(rst), .start(s0_start), .abort(s0_abort), .out_ready(s0_ready),
    .out_valid(s0_valid), .out_state(s0_state), .out_last(s0_last), .busy(s0_busy),
    .done(s0_done), .pass_cnt(s0_pass), .state_dbg(s0_dbg)
  );

  trigger_sequence_injector #(.GAP_CYCLES(2), .REPEAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .abort(s1_abort), .out_ready(s1_ready),
    .out_valid(s1_valid), .out_state(s1_state), .out_last(s1_last), .busy(s1_busy),
    .done(s1_done), .pass_cnt(s1_pass), .state_dbg(s1_dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic v, input logic [127:0] s,
                      input logic l, input logic b, input logic d);
    chk({tag, "_valid"}, 128'(s0_valid), 128'(v));
    chk({tag, "_state"}, s0_state, s);
    chk({tag, "_last"},  128'(s0_last),  128'(l));
    chk({tag, "_busy"},  128'(s0_busy),  128'(b));
    chk({tag, "_done"},  128'(s0_done),  128'(d));
  endtask

  // Full GAP=2/REPEAT=2 run, entered on the cycle W0 first appears.
  task automatic run_dut1_full(input string tag);
    int n_done = 0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_w_valid"}, 128'(s1_valid), 128'd1);
      chk({tag, "_w_state"}, s1_state, wv[k % 4]);
      chk({tag, "_w_last"},  128'(s1_last), 128'(k == 7));
      step();
      if (k < 7) begin
        for (int g = 0; g < 2; g++) begin
          chk({tag, "_gap_valid"}, 128'(s1_valid), 128'd0);
          chk({tag, "_gap_state"}, s1_state, 128'd0);
          chk({tag, "_gap_busy"},  128'(s1_busy), 128'd1);
          if (s1_done) n_done++;
          step();
        end
      end
    end
    chk({tag, "_done"}, 128'(s1_done), 128'd1);
    chk({tag, "_pass"}, 128'(s1_pass), 128'd2);
    chk({tag, "_early_done"}, 128'(n_done), 128'd0);
    step();
    chk({tag, "_idle_busy"}, 128'(s1_busy), 128'd0);
    chk({tag, "_idle_done"}, 128'(s1_done), 128'd0);
  endtask

  initial begin
    wv[0] = 128'h3243f6a8_885a308d_313198a2_e0370734;
    wv[1] = 128'h00112233_44556677_8899aabb_ccddeeff;
    wv[2] = 128'h0;
    wv[3] = 128'h1;

    // Reset state
    step(); step();
    chk0("rst0", 0, 0, 0, 0, 0);
    chk("rst0_pass", 128'(s0_pass), 128'd0);
    chk("rst0_dbg",  128'(s0_dbg),  128'd0);
    rst = 1'b0;
    step();
    chk0("idle0", 0, 0, 0, 0, 0);

    // Back-to-back run, ready constant high
    s0_ready = 1; s0_start = 1;
    step();
    s0_start = 0;
    chk0("b2b_w0", 1, wv[0], 0, 1, 0);
    step(); chk0("b2b_w1", 1, wv[1], 0, 1, 0);
    step(); chk0("b2b_w2", 1, wv[2], 0, 1, 0);
    step(); chk0("b2b_w3", 1, wv[3], 1, 1, 0);
    step(); chk0("b2b_done", 0, 0, 0, 1, 1);
    chk("b2b_pass", 128'(s0_pass), 128'd1);
    step(); chk0("b2b_idle", 0, 0, 0, 0, 0);
    chk("b2b_pass_hold", 128'(s0_pass), 128'd1);

    // Stall W1 for three cycles
    s0_start = 1;
    step(); s0_start = 0;
    chk0("stall_w0", 1, wv[0], 0, 1, 0);
    chk("stall_pass_clr", 128'(s0_pass), 128'd0);
    step();
    s0_ready = 0;
    chk0("stall_w1_a", 1, wv[1], 0, 1, 0);
    step(); chk0("stall_w1_b", 1, wv[1], 0, 1, 0);
    step(); chk0("stall_w1_c", 1, wv[1], 0, 1, 0);
    s0_ready = 1;
    step(); chk0("stall_w2", 1, wv[2], 0, 1, 0);
    step(); chk0("stall_w3", 1, wv[3], 1, 1, 0);
    step(); chk0("stall_done", 0, 0, 0, 1, 1);
    step(); chk0("stall_idle", 0, 0, 0, 0, 0);

    // Abort while W2 stalled, then restart from W0
    s0_start = 1;
    step(); s0_start = 0;
    chk0("ab_w0", 1, wv[0], 0, 1, 0);
    step(); chk0("ab_w1", 1, wv[1], 0, 1, 0);
    step(); s0_ready = 0;
    chk0("ab_w2", 1, wv[2], 0, 1, 0);
    step(); chk0("ab_w2_hold", 1, wv[2], 0, 1, 0);
    s0_abort = 1;
    step(); s0_abort = 0;
    chk0("ab_after", 0, 0, 0, 0, 0);
    chk("ab_pass", 128'(s0_pass), 128'd0);
    step(); chk0("ab_quiet", 0, 0, 0, 0, 0);
    s0_ready = 1; s0_start = 1;
    step(); s0_start = 0;
    chk0("ab_restart_w0", 1, wv[0], 0, 1, 0);
    step(); step(); step();
    chk0("ab_restart_w3", 1, wv[3], 1, 1, 0);
    step(); chk0("ab_restart_done", 0, 0, 0, 1, 1);
    step();

    // Start during a run ignored; start with abort -> abort wins
    s0_start = 1;
    step(); s0_start = 0;
    chk0("ign_w0", 1, wv[0], 0, 1, 0);
    step(); s0_start = 1;
    chk0("ign_w1", 1, wv[1], 0, 1, 0);
    step(); s0_start = 0;
    chk0("ign_w2", 1, wv[2], 0, 1, 0);
    s0_start = 1; s0_abort = 1;
    step(); s0_start = 0; s0_abort = 0;
    chk0("ign_abort", 0, 0, 0, 0, 0);
    step(); chk0("ign_stay_idle", 0, 0, 0, 0, 0);

    // Gapped two-pass run
    s1_ready = 1; s1_start = 1;
    step(); s1_start = 0;
    run_dut1_full("gap");

    // Asynchronous reset mid-gap
    s1_start = 1;
    step(); s1_start = 0;
    chk("rg_w0", s1_state, wv[0]);
    step();
    chk("rg_gap_valid", 128'(s1_valid), 128'd0);
    chk("rg_gap_busy",  128'(s1_busy),  128'd1);
    #2 rst = 1'b1;
    #1;
    chk("rg_rst_busy",  128'(s1_busy),  128'd0);
    chk("rg_rst_valid", 128'(s1_valid), 128'd0);
    chk("rg_rst_state", s1_state, 128'd0);
    chk("rg_rst_pass",  128'(s1_pass),  128'd0);
    chk("rg_rst_dbg",   128'(s1_dbg),   128'd0);
    rst = 1'b0;
    step();
    chk("rg_post_busy", 128'(s1_busy), 128'd0);
    s1_start = 1;
    step(); s1_start = 0;
    run_dut1_full("rg_full");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
